// File: rtl/tsg_pkg.sv
// Shared types and constants for the test signal generator.
//   tsg_mode_e : waveform selection (triangle, sawtooth, square, constant)
//   tsg_dir_e  : triangle slope direction
//   TSG_OVR_W  : width of the saturating overrun counter
package tsg_pkg;

  typedef enum logic [1:0] {
    TSG_TRIANGLE = 2'd0,
    TSG_SAWTOOTH = 2'd1,
    TSG_SQUARE   = 2'd2,
    TSG_CONST    = 2'd3
  } tsg_mode_e;

  typedef enum logic {
    TSG_UP   = 1'b0,
    TSG_DOWN = 1'b1
  } tsg_dir_e;

  localparam int unsigned TSG_OVR_W = 8;

endpackage

// File: rtl/tsg_divider.sv
// Sample-rate tick generator: one-cycle tick every div+1 cycles while enabled.
//   clk, rst  : clock, synchronous active-high reset
//   enable    : count runs when 1; 0 clears the count
//   restart   : clears the count and suppresses the tick this cycle
//   div       : divide value (0 = tick every cycle)
//   tick      : combinational tick strobe
module tsg_divider #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count;

  assign tick = enable && !restart && (count == div);

  always_ff @(posedge clk) begin
    if (rst || restart || !enable || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/test_signal_gen.sv
// Multi-channel test waveform generator with valid/ready output handshake.
//   clk, rst     : clock, synchronous active-high reset
//   enable       : lets the sample-rate divider run
//   cfg_mode     : 0 triangle, 1 sawtooth, 2 square, 3 constant
//   cfg_step     : per-sample increment (constant value in mode 3)
//   cfg_div      : one tick every cfg_div+1 cycles
//   cfg_load     : pulse latching cfg_* and restarting the generator
//   data_out     : channel k in bits [k*WIDTH +: WIDTH], phase offset k*2^WIDTH/CHANNELS
//   data_valid   : sample available; data_ready accepts it
//   overrun_cnt  : saturating count of ticks lost to backpressure
// Optional build macro TSG_DITHER_EN adds a 16-bit LFSR dither on each channel LSB.
module test_signal_gen
  import tsg_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [1:0]                cfg_mode,
  input  logic [WIDTH-1:0]          cfg_step,
  input  logic [DIV_WIDTH-1:0]      cfg_div,
  input  logic                      cfg_load,
  output logic [CHANNELS*WIDTH-1:0] data_out,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic [TSG_OVR_W-1:0]      overrun_cnt
);

  localparam logic [WIDTH-1:0] MID     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX     = '1;
  localparam int unsigned      CH_OFS  = (2**WIDTH) / CHANNELS;

  tsg_mode_e              sh_mode;
  logic [WIDTH-1:0]       sh_step;
  logic [DIV_WIDTH-1:0]   sh_div;
  logic [WIDTH-1:0]       base;
  tsg_dir_e               dir;
  logic [CHANNELS*WIDTH-1:0] data_r;
  logic                   tick;
  logic                   accept;
  logic                   blocked;

  logic [WIDTH:0]         sum;
  logic [WIDTH-1:0]       adv_base;
  tsg_dir_e               adv_dir;
  logic [WIDTH-1:0]       eff_base;

  assign accept  = data_valid && data_ready;
  assign blocked = data_valid && !data_ready;

  tsg_divider #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .restart (cfg_load),
    .div     (sh_div),
    .tick    (tick)
  );

  // Expands a base/phase value into all channels; square mode thresholds the
  // offset phase instead of emitting it directly.
  function automatic logic [CHANNELS*WIDTH-1:0] render(input logic [WIDTH-1:0] b,
                                                        input tsg_mode_e m);
    logic [CHANNELS*WIDTH-1:0] r;
    logic [WIDTH-1:0]          ph;
    r = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      ph = b + WIDTH'(k * CH_OFS);
      r[k*WIDTH +: WIDTH] = (m == TSG_SQUARE) ? {WIDTH{ph[WIDTH-1]}} : ph;
    end
    return r;
  endfunction

  always_comb begin
    sum      = {1'b0, base} + {1'b0, sh_step};
    adv_base = base;
    adv_dir  = dir;
    eff_base = (sh_mode == TSG_CONST) ? sh_step : base;
    case (sh_mode)
      TSG_TRIANGLE: begin
        if (sh_step != '0) begin
          if (dir == TSG_UP) begin
            if (sum >= {1'b0, MAX}) begin
              adv_base = MAX;
              adv_dir  = TSG_DOWN;
            end else begin
              adv_base = sum[WIDTH-1:0];
            end
          end else begin
            if (base <= sh_step) begin
              adv_base = '0;
              adv_dir  = TSG_UP;
            end else begin
              adv_base = base - sh_step;
            end
          end
        end
      end
      TSG_SAWTOOTH, TSG_SQUARE: adv_base = sum[WIDTH-1:0];
      default:                  adv_base = sh_step;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_mode     <= TSG_TRIANGLE;
      sh_step     <= WIDTH'(1);
      sh_div      <= '0;
      base        <= MID;
      dir         <= TSG_UP;
      data_valid  <= 1'b0;
      overrun_cnt <= '0;
      data_r      <= '0;
    end else if (cfg_load) begin
      sh_mode     <= tsg_mode_e'(cfg_mode);
      sh_step     <= cfg_step;
      sh_div      <= cfg_div;
      base        <= MID;
      dir         <= TSG_UP;
      data_valid  <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      if (accept) begin
        base <= adv_base;
        dir  <= adv_dir;
      end
      if (tick) begin
        if (blocked) begin
          if (overrun_cnt != '1) begin
            overrun_cnt <= overrun_cnt + 1'b1;
          end
        end else begin
          // A tick coinciding with accept presents the freshly advanced value.
          data_valid <= 1'b1;
          data_r     <= accept ? render(adv_base, sh_mode) : render(eff_base, sh_mode);
        end
      end else if (accept) begin
        data_valid <= 1'b0;
      end
    end
  end

`ifdef TSG_DITHER_EN
  logic [15:0]               lfsr;
  logic [CHANNELS*WIDTH-1:0] dither_mask;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else if (accept) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_comb begin
    dither_mask = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      dither_mask[k*WIDTH] = lfsr[0];
    end
  end

  assign data_out = data_r ^ dither_mask;
`else
  assign data_out = data_r;
`endif

endmodule

// File: tb/tb_test_signal_gen.sv
module tb_test_signal_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_step;
  logic [15:0] cfg_div;
  logic        cfg_load;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_ready;
  logic [7:0]  overrun_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  test_signal_gen #(
    .WIDTH(8),
    .CHANNELS(2),
    .DIV_WIDTH(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .cfg_mode    (cfg_mode),
    .cfg_step    (cfg_step),
    .cfg_div     (cfg_div),
    .cfg_load    (cfg_load),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .overrun_cnt (overrun_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_cfg(input logic [1:0] m, input logic [7:0] s, input logic [15:0] d);
    @(negedge clk);
    cfg_mode = m;
    cfg_step = s;
    cfg_div  = d;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!data_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!data_valid) check(tag, 32'(data_valid), 32'd1);
  endtask

  logic [7:0]  tri_exp  [8] = '{8'h80, 8'hC0, 8'hFF, 8'hBF, 8'h7F, 8'h3F, 8'h00, 8'h40};
  logic [7:0]  saw0_exp [4] = '{8'h80, 8'hE0, 8'h40, 8'hA0};
  logic [7:0]  saw1_exp [4] = '{8'h00, 8'h60, 8'hC0, 8'h20};
  logic [7:0]  sq0_exp  [3] = '{8'hFF, 8'h00, 8'hFF};
  logic [7:0]  sq1_exp  [3] = '{8'h00, 8'hFF, 8'h00};
  logic [15:0] snap;

  initial begin
    rst = 1'b1; enable = 1'b1; data_ready = 1'b0;
    cfg_mode = 2'd0; cfg_step = 8'h01; cfg_div = 16'd0; cfg_load = 1'b0;

    // Reset state and first sample
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_ovr", 32'(overrun_cnt), 32'd0);
    wait_valid("rst_first_timeout");
    check("rst_ch0", 32'(data_out[7:0]), 32'h80);
    check("rst_ch1", 32'(data_out[15:8]), 32'h00);

    // Triangle
    data_ready = 1'b1;
    load_cfg(2'd0, 8'h40, 16'd0);
    wait_valid("tri_timeout");
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tri_ch0[%0d]", i), 32'(data_out[7:0]), 32'(tri_exp[i]));
      @(negedge clk);
    end

    // Sawtooth
    load_cfg(2'd1, 8'h60, 16'd0);
    wait_valid("saw_timeout");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("saw_ch0[%0d]", i), 32'(data_out[7:0]), 32'(saw0_exp[i]));
      check($sformatf("saw_ch1[%0d]", i), 32'(data_out[15:8]), 32'(saw1_exp[i]));
      @(negedge clk);
    end

    // Square
    load_cfg(2'd2, 8'h80, 16'd0);
    wait_valid("sq_timeout");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("sq_ch0[%0d]", i), 32'(data_out[7:0]), 32'(sq0_exp[i]));
      check($sformatf("sq_ch1[%0d]", i), 32'(data_out[15:8]), 32'(sq1_exp[i]));
      @(negedge clk);
    end

    // Zero step holds the base in triangle mode
    load_cfg(2'd0, 8'h00, 16'd0);
    wait_valid("step0_timeout");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("step0_ch0[%0d]", i), 32'(data_out[7:0]), 32'h80);
      @(negedge clk);
    end

    // Backpressure with div=3
    data_ready = 1'b0;
    load_cfg(2'd1, 8'h10, 16'd3);
    wait_valid("bp_timeout");
    snap = data_out;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("bp_ovr10", 32'(overrun_cnt), 32'd10);
    check("bp_stable", 32'(data_out), 32'(snap));
    check("bp_valid", 32'(data_valid), 32'd1);
    repeat (1200) @(posedge clk);
    @(negedge clk);
    check("bp_ovr_sat", 32'(overrun_cnt), 32'd255);
    check("bp_stable2", 32'(data_out), 32'(snap));

    // Mid-run reconfiguration to constant mode
    load_cfg(2'd3, 8'h33, 16'd0);
    check("ld_valid", 32'(data_valid), 32'd0);
    check("ld_ovr", 32'(overrun_cnt), 32'd0);
    wait_valid("const_timeout");
    check("const_ch0", 32'(data_out[7:0]), 32'h33);
    check("const_ch1", 32'(data_out[15:8]), 32'hB3);
    data_ready = 1'b1;
    @(negedge clk);
    check("const_ch0_next", 32'(data_out[7:0]), 32'h33);
    check("const_valid_next", 32'(data_valid), 32'd1);

    // Reset mid-operation discards the pending sample
    data_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst2_valid", 32'(data_valid), 32'd0);
    check("rst2_ovr", 32'(overrun_cnt), 32'd0);
    wait_valid("rst2_timeout");
    check("rst2_ch0", 32'(data_out[7:0]), 32'h80);
    check("rst2_ch1", 32'(data_out[15:8]), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
